ram_uart_streamer: RTL
======================

// Module: ram_uart_streamer
// PURPOSE
//  Downstream drain stage for the image data memory: after processing, it reads LEN words sequentially
//  from the data RAM and hands them, one byte at a time, to the UART transmitter.
//  Replaces the ad-hoc ram_to_pc logic in the top-level FSM with a clean start/busy/done engine.
//  Owns RAM read-port control and the UART tx handshake while busy; releases both when idle.
// PARAMETERS
//  ADDR_W   16     RAM address width
//  DATA_W   16     RAM data width (8 or 16)
//  LEN      16384  number of RAM words streamed per run (0 permitted)
//  BASE     0      first RAM address read
//  TWO_BYTE 0      1: send low byte then high byte per word (needs DATA_W=16); 0: send low byte only
// PORTS
//  clk          in   1       system clock
//  reset        in   1       synchronous, active-high reset
//  start        in   1       one-cycle request to begin a run (ignored while busy)
//  abort        in   1       cancel current run
//  busy         out  1       high from cycle after accepted start until DONE/abort
//  done         out  1       one-cycle pulse when last byte's tx_done_tick is seen
//  ram_en       out  1       RAM enable (read)
//  ram_we       out  1       RAM write enable, constant 0
//  ram_addr     out  ADDR_W  RAM read address
//  ram_rdata    in   DATA_W  RAM read data, valid 1 cycle after ram_en/ram_addr
//  tx_start     out  1       one-cycle pulse: UART latches tx_in
//  tx_in        out  8       byte to transmit, held stable until tx_done_tick
//  tx_done_tick in   1       UART pulse: current byte fully shifted out
//  word_cnt     out  ADDR_W  words completed in current/last run
// BEHAVIOUR
//  Reset: busy=0 done=0 ram_en=0 ram_we=0 ram_addr=BASE tx_start=0 tx_in=0 word_cnt=0, state IDLE.
//  FSM: IDLE -> RD_REQ -> RD_WAIT -> TX_LO -> WAIT_LO -> [TX_HI -> WAIT_HI] -> NEXT -> RD_REQ | FIN -> IDLE.
//  IDLE: start=1 -> word_cnt<=0, ram_addr<=BASE; if LEN==0 -> FIN, else RD_REQ.
//  RD_REQ: ram_en=1 for exactly this cycle with ram_addr. RD_WAIT: capture ram_rdata into word register.
//  TX_LO: tx_in<=word[7:0], tx_start=1 for one cycle. WAIT_LO: hold tx_in; wait tx_done_tick.
//  TX_HI/WAIT_HI only when TWO_BYTE=1, with word[15:8].
//  NEXT: word_cnt+1; ram_addr+1 (wraps modulo 2^ADDR_W); if word_cnt+1==LEN -> FIN else RD_REQ.
//  FIN: done=1 one cycle, busy drops same edge state returns to IDLE.
//  Latency: start -> first tx_start = 4 clocks (IDLE, RD_REQ, RD_WAIT, TX_LO).
//  Between bytes: tx_done_tick -> next tx_start = 1 clock (hi byte) or 4 clocks (next word).
//  tx_done_tick outside WAIT_* states is ignored; one tick advances exactly one byte.
//  start while busy ignored; start and abort same cycle in IDLE -> abort wins, stays IDLE.
//  abort in any busy state -> IDLE next edge; no done pulse; word_cnt frozen; tx_start forced 0.
//    A byte already in the UART finishes on the line; its tick is ignored.
//  reset mid-run: all outputs to reset values on the next edge, regardless of state.
//  done and start same cycle: new run accepted from IDLE the cycle after FIN.
// STRUCTURE
//  Shared package (img_sys_pkg): state encoding localparams, ADDR_W/DATA_W defaults, IMG_LEN=16384.
//  No sub-module: single FSM plus address/word counters and a byte mux; 150-250 lines.
//  Top-level muxes RAM port between loader, processor and this block by its own mode FSM.
// TESTING
//  LEN=4, BASE=0, RAM={0x0011,0x0022,0x0033,0x0044}, TWO_BYTE=0, UART model ticks 10 clk after tx_start
//    -> tx_in sequence 11,22,33,44; one done pulse; word_cnt=4.
//  Same RAM, TWO_BYTE=1 -> bytes 11,00,22,00,33,00,44,00; 8 tx_start pulses; done once.
//  LEN=0, start -> done pulse 2 cycles after start, no ram_en, no tx_start.
//  Abort asserted during WAIT_LO of word 2 -> IDLE next clk, busy=0, no done, word_cnt=2; late tick ignored.
//  BASE=0xFFFE, LEN=3 -> ram_addr 0xFFFE, 0xFFFF, 0x0000 (wrap); start pulsed mid-run ignored.
//  Reset asserted in TX_LO -> next clk all outputs at reset values; fresh start runs full LEN correctly.

Source files
------------

// File: rtl/ram_uart_streamer_pkg.sv
// Shared definitions for the RAM-to-UART drain engine: FSM encoding,
// default widths and the byte-lane helper.
package ram_uart_streamer_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned IMG_LEN    = 16384;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RD_REQ  = 4'd1,
    ST_RD_WAIT = 4'd2,
    ST_TX_LO   = 4'd3,
    ST_WAIT_LO = 4'd4,
    ST_TX_HI   = 4'd5,
    ST_WAIT_HI = 4'd6,
    ST_NEXT    = 4'd7,
    ST_FIN     = 4'd8
  } state_e;

  function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
    byte_sel = hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/ram_uart_streamer.sv
// Streams LEN words from the data RAM to the UART transmitter, one byte
// per tx handshake; start/busy/done control with abort.
module ram_uart_streamer
  import ram_uart_streamer_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned LEN      = IMG_LEN,
  parameter int unsigned BASE     = 0,
  parameter bit          TWO_BYTE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              tx_start,
  output logic [7:0]        tx_in,
  input  logic              tx_done_tick,
  output logic [ADDR_W-1:0] word_cnt
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   LEN_C  = (ADDR_W+1)'(LEN);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [15:0]       word_q, word_d;
  logic [7:0]        tx_in_q, tx_in_d;
  logic              busy_q, done_q, ram_en_q, tx_start_q;
  logic [ADDR_W:0]   cnt_next_s;

  // Extra MSB so a full 2^ADDR_W run still terminates on the compare.
  assign cnt_next_s = {1'b0, word_cnt_q} + {{ADDR_W{1'b0}}, 1'b1};

  // Next-state, counter and byte-register logic.
  always_comb begin
    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    word_cnt_d = word_cnt_q;
    word_d     = word_q;
    tx_in_d    = tx_in_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          word_cnt_d = '0;
          ram_addr_d = BASE_A;
          state_d    = (LEN == 0) ? ST_FIN : ST_RD_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_REQ:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        word_d  = 16'(ram_rdata);
        tx_in_d = byte_sel(16'(ram_rdata), 1'b0);
        state_d = ST_TX_LO;
      end
      ST_TX_LO:   state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (tx_done_tick) begin
          if (TWO_BYTE) begin
            tx_in_d = byte_sel(word_q, 1'b1);
            state_d = ST_TX_HI;
          end else begin
            state_d = ST_NEXT;
          end
        end else begin
          state_d = ST_WAIT_LO;
        end
      end
      ST_TX_HI:   state_d = ST_WAIT_HI;
      ST_WAIT_HI: state_d = tx_done_tick ? ST_NEXT : ST_WAIT_HI;
      ST_NEXT: begin
        word_cnt_d = cnt_next_s[ADDR_W-1:0];
        ram_addr_d = ram_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        state_d    = (cnt_next_s == LEN_C) ? ST_FIN : ST_RD_REQ;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort discards everything this cycle would have committed.
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      ram_addr_d = ram_addr_q;
      word_cnt_d = word_cnt_q;
      word_d     = word_q;
      tx_in_d    = tx_in_q;
    end else begin
      state_d = state_d;
    end
  end

  // State, datapath and registered control outputs (decoded from next state).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ram_addr_q <= BASE_A;
      word_cnt_q <= '0;
      word_q     <= 16'h0000;
      tx_in_q    <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ram_en_q   <= 1'b0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      word_cnt_q <= word_cnt_d;
      word_q     <= word_d;
      tx_in_q    <= tx_in_d;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_FIN);
      ram_en_q   <= (state_d == ST_RD_REQ);
      tx_start_q <= (state_d == ST_TX_LO) || (state_d == ST_TX_HI);
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ram_en   = ram_en_q;
  assign ram_we   = 1'b0;
  assign ram_addr = ram_addr_q;
  assign tx_start = tx_start_q;
  assign tx_in    = tx_in_q;
  assign word_cnt = word_cnt_q;

endmodule
